// File: rtl/fsic_serdes_link_init_pkg.sv
// rtl/fsic_serdes_link_init_pkg.sv - shared types and constants for the serdes link bring-up master
package fsic_serdes_init_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_RX,
        ST_DLY,
        ST_WR_TX,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE,
        ST_ERR
    } init_state_e;

    localparam logic [11:0] SERDES_CTRL_OFFSET = 12'h000;

    localparam int RXEN_BIT = 0;
    localparam int TXEN_BIT = 1;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_WR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_RD_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_MISMATCH   = 2'b11;

endpackage

// File: rtl/fsic_serdes_link_init_if.sv
// rtl/fsic_serdes_link_init_if.sv - AXI-Lite aw/w/ar/r channels toward the serdes config port
// master: driven by fsic_serdes_link_init; slave: the serdes register block.
interface fsic_serdes_link_init_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
) ();
    logic                   axi_awvalid;
    logic [pADDR_WIDTH-1:0] axi_awaddr;
    logic                   axi_awready;
    logic                   axi_wvalid;
    logic [pDATA_WIDTH-1:0] axi_wdata;
    logic [3:0]             axi_wstrb;
    logic                   axi_wready;
    logic                   axi_arvalid;
    logic [pADDR_WIDTH-1:0] axi_araddr;
    logic                   axi_arready;
    logic                   axi_rvalid;
    logic [pDATA_WIDTH-1:0] axi_rdata;
    logic                   axi_rready;

    modport master (
        output axi_awvalid, axi_awaddr, input axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, input axi_wready,
        output axi_arvalid, axi_araddr, input axi_arready,
        input axi_rvalid, axi_rdata, output axi_rready
    );

    modport slave (
        input axi_awvalid, axi_awaddr, output axi_awready,
        input axi_wvalid, axi_wdata, axi_wstrb, output axi_wready,
        input axi_arvalid, axi_araddr, output axi_arready,
        output axi_rvalid, axi_rdata, input axi_rready
    );
endinterface

// File: rtl/fsic_serdes_link_init_cfg_cnt.sv
// rtl/fsic_serdes_link_init_cfg_cnt.sv - saturating up-counter with terminal flag for delay and timeout
// Ports: axi_clk/axi_reset_n clock and async active-low reset; clr restarts at 0;
// en advances; limit sets the terminal count; term is high once count >= limit-1.
module fsic_cfg_cnt #(
    parameter int pWIDTH = 8
) (
    input  logic              axi_clk,
    input  logic              axi_reset_n,
    input  logic              clr,
    input  logic              en,
    input  logic [pWIDTH-1:0] limit,
    output logic              term
);
    logic [pWIDTH-1:0] count;

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // count starts at 0 in the first cycle of a phase, so limit-1 marks the
    // last cycle of a phase that lasts limit cycles.
    assign term = (count >= (limit - 1'b1));
endmodule

// File: rtl/fsic_serdes_link_init.sv
// rtl/fsic_serdes_link_init.sv - AXI-Lite master bringing up the serdes link (rxen, then rxen+txen, readback)
// Ports: axi_clk, axi_reset_n (async active-low); start pulse; busy/done/error/err_code status;
// cc_ls_enable high while busy; cfg carries the aw/w/ar/r channels as master.
module fsic_serdes_link_init
    import fsic_serdes_init_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTX_DELAY   = 16,
    parameter int pTIMEOUT    = 255
) (
    input  logic       axi_clk,
    input  logic       axi_reset_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       cc_ls_enable,
    fsic_serdes_link_init_if.master cfg
);
    localparam int CNT_MAX = (pTX_DELAY > pTIMEOUT) ? pTX_DELAY : pTIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [pADDR_WIDTH-1:0] CTRL_ADDR = pADDR_WIDTH'(SERDES_CTRL_OFFSET);
    localparam logic [pDATA_WIDTH-1:0] RX_WORD   = pDATA_WIDTH'(1 << RXEN_BIT);
    localparam logic [pDATA_WIDTH-1:0] TX_WORD   = pDATA_WIDTH'((1 << RXEN_BIT) | (1 << TXEN_BIT));

    init_state_e        state;
    logic               aw_done, w_done;
    logic               aw_hs, w_hs, ar_hs, r_hs, wr_ok;
    logic               phase_ok, in_hs_phase, start_acc;
    logic               cnt_clr, cnt_en, cnt_term;
    logic [CNT_W-1:0]   cnt_limit;
    logic               unused_rdata;

    assign aw_hs = cfg.axi_awvalid & cfg.axi_awready;
    assign w_hs  = cfg.axi_wvalid & cfg.axi_wready;
    assign ar_hs = cfg.axi_arvalid & cfg.axi_arready;
    assign r_hs  = cfg.axi_rready & cfg.axi_rvalid;
    // A write phase completes once both channels have handshaken, now or earlier.
    assign wr_ok = (aw_done | aw_hs) & (w_done | w_hs);

    always_comb begin
        phase_ok = 1'b0;
        case (state)
            ST_WR_RX, ST_WR_TX: phase_ok = wr_ok;
            ST_DLY:             phase_ok = cnt_term;
            ST_RD_ADDR:         phase_ok = ar_hs;
            ST_RD_DATA:         phase_ok = r_hs;
            default:            phase_ok = 1'b0;
        endcase
    end

    assign in_hs_phase = state inside {ST_WR_RX, ST_WR_TX, ST_RD_ADDR, ST_RD_DATA};
    assign start_acc   = start & (state inside {ST_IDLE, ST_DONE, ST_ERR});
    // Clear on every state change so each phase counts from 0 in its first cycle.
    assign cnt_clr     = start_acc | phase_ok | (in_hs_phase & cnt_term);
    assign cnt_en      = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign cnt_limit   = (state == ST_DLY) ? CNT_W'(pTX_DELAY) : CNT_W'(pTIMEOUT);
    assign unused_rdata = ^cfg.axi_rdata[pDATA_WIDTH-1:2];

    fsic_cfg_cnt #(.pWIDTH(CNT_W)) u_cnt (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .clr         (cnt_clr),
        .en          (cnt_en),
        .limit       (cnt_limit),
        .term        (cnt_term)
    );

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            state            <= ST_IDLE;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            busy             <= 1'b0;
            cc_ls_enable     <= 1'b0;
            done             <= 1'b0;
            error            <= 1'b0;
            err_code         <= ERR_NONE;
            cfg.axi_awvalid  <= 1'b0;
            cfg.axi_awaddr   <= '0;
            cfg.axi_wvalid   <= 1'b0;
            cfg.axi_wdata    <= '0;
            cfg.axi_wstrb    <= 4'h0;
            cfg.axi_arvalid  <= 1'b0;
            cfg.axi_araddr   <= '0;
            cfg.axi_rready   <= 1'b0;
        end else begin
            // Each write channel drops its valid the cycle after its own ready.
            if (aw_hs) begin
                cfg.axi_awvalid <= 1'b0;
                aw_done         <= 1'b1;
            end
            if (w_hs) begin
                cfg.axi_wvalid <= 1'b0;
                w_done         <= 1'b1;
            end

            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state           <= ST_WR_RX;
                        busy            <= 1'b1;
                        cc_ls_enable    <= 1'b1;
                        done            <= 1'b0;
                        error           <= 1'b0;
                        err_code        <= ERR_NONE;
                        cfg.axi_awvalid <= 1'b1;
                        cfg.axi_awaddr  <= CTRL_ADDR;
                        cfg.axi_wvalid  <= 1'b1;
                        cfg.axi_wdata   <= RX_WORD;
                        cfg.axi_wstrb   <= 4'hF;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                    end
                end
                ST_WR_RX, ST_WR_TX: begin
                    if (wr_ok) begin
                        if (state == ST_WR_RX) begin
                            state <= ST_DLY;
                        end else begin
                            state           <= ST_RD_ADDR;
                            cfg.axi_arvalid <= 1'b1;
                            cfg.axi_araddr  <= CTRL_ADDR;
                        end
                    end else if (cnt_term) begin
                        state           <= ST_ERR;
                        cfg.axi_awvalid <= 1'b0;
                        cfg.axi_wvalid  <= 1'b0;
                        busy            <= 1'b0;
                        cc_ls_enable    <= 1'b0;
                        error           <= 1'b1;
                        err_code        <= ERR_WR_TIMEOUT;
                    end
                end
                ST_DLY: begin
                    if (cnt_term) begin
                        state           <= ST_WR_TX;
                        cfg.axi_awvalid <= 1'b1;
                        cfg.axi_wvalid  <= 1'b1;
                        cfg.axi_wdata   <= TX_WORD;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                    end
                end
                ST_RD_ADDR: begin
                    if (ar_hs) begin
                        state           <= ST_RD_DATA;
                        cfg.axi_arvalid <= 1'b0;
                        cfg.axi_rready  <= 1'b1;
                    end else if (cnt_term) begin
                        state           <= ST_ERR;
                        cfg.axi_arvalid <= 1'b0;
                        busy            <= 1'b0;
                        cc_ls_enable    <= 1'b0;
                        error           <= 1'b1;
                        err_code        <= ERR_RD_TIMEOUT;
                    end
                end
                ST_RD_DATA: begin
                    if (r_hs) begin
                        cfg.axi_rready <= 1'b0;
                        busy           <= 1'b0;
                        cc_ls_enable   <= 1'b0;
                        if (cfg.axi_rdata[1:0] == 2'b11) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_ERR;
                            error    <= 1'b1;
                            err_code <= ERR_MISMATCH;
                        end
                    end else if (cnt_term) begin
                        state          <= ST_ERR;
                        cfg.axi_rready <= 1'b0;
                        busy           <= 1'b0;
                        cc_ls_enable   <= 1'b0;
                        error          <= 1'b1;
                        err_code       <= ERR_RD_TIMEOUT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fsic_serdes_link_init.sv
// tb/tb_fsic_serdes_link_init.sv - scoreboard bench for fsic_serdes_link_init
module tb_fsic_serdes_link_init;
    import fsic_serdes_init_pkg::*;

    localparam int TX_DLY = 16;
    localparam int TMO    = 255;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    typedef struct packed {
        logic        done;
        logic        error;
        logic [1:0]  code;
        logic [31:0] cyc;
    } stat_t;

    logic       axi_clk = 1'b0;
    logic       axi_reset_n;
    logic       start;
    logic       busy, done, error, cc_ls_enable;
    logic [1:0] err_code;

    fsic_serdes_link_init_if #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) cfg ();

    fsic_serdes_link_init #(
        .pADDR_WIDTH (12),
        .pDATA_WIDTH (32),
        .pTX_DELAY   (TX_DLY),
        .pTIMEOUT    (TMO)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset_n  (axi_reset_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_code     (err_code),
        .cc_ls_enable (cc_ls_enable),
        .cfg          (cfg)
    );

    always #5 axi_clk = ~axi_clk;

    logic [11:0] exp_aw[$];
    wbeat_t      exp_w[$];
    logic [11:0] exp_ar[$];
    stat_t       exp_st[$];

    int  total = 0;
    int  bad   = 0;
    time t_start = 0;
    int  awv_cyc = 0;
    int  wv_cyc  = 0;

    int   aw_dly = 0;
    int   w_dly  = 0;
    logic bad_rd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Serdes register slave: readies after a programmable wait, register holds last written word.
    initial begin
        int awc = 0;
        int wc  = 0;
        logic [31:0] sl_reg = 32'h0;
        cfg.axi_awready = 1'b0;
        cfg.axi_wready  = 1'b0;
        cfg.axi_arready = 1'b0;
        cfg.axi_rvalid  = 1'b0;
        cfg.axi_rdata   = 32'h0;
        forever begin
            @(negedge axi_clk);
            if (cfg.axi_wvalid && cfg.axi_wready) sl_reg = cfg.axi_wdata;
            @(posedge axi_clk);
            #1;
            awc = cfg.axi_awvalid ? awc + 1 : 0;
            wc  = cfg.axi_wvalid ? wc + 1 : 0;
            cfg.axi_awready = cfg.axi_awvalid ? (awc > aw_dly) : (aw_dly == 0);
            cfg.axi_wready  = cfg.axi_wvalid ? (wc > w_dly) : (w_dly == 0);
            cfg.axi_arready = 1'b1;
            cfg.axi_rvalid  = 1'b1;
            cfg.axi_rdata   = bad_rd ? 32'h0000_0001 : sl_reg;
        end
    end

    task automatic monitor();
        logic        prev_fin = 1'b0;
        logic [31:0] cur;
        stat_t       s;
        forever begin
            @(negedge axi_clk);
            if (cfg.axi_awvalid) awv_cyc++;
            if (cfg.axi_wvalid)  wv_cyc++;
            if (cfg.axi_awvalid && cfg.axi_awready) begin
                if (exp_aw.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("aw_addr", 64'(cfg.axi_awaddr), 64'(exp_aw.pop_front()));
            end
            if (cfg.axi_wvalid && cfg.axi_wready) begin
                if (exp_w.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("w_beat", 64'({cfg.axi_wdata, cfg.axi_wstrb}), 64'(exp_w.pop_front()));
            end
            if (cfg.axi_arvalid && cfg.axi_arready) begin
                if (exp_ar.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                else check("ar_addr", 64'(cfg.axi_araddr), 64'(exp_ar.pop_front()));
            end
            if ((done || error) && !prev_fin) begin
                cur = 32'(($time - t_start + 5) / 10);
                if (exp_st.size() == 0) begin
                    check("status_unexpected", 64'd1, 64'd0);
                end else begin
                    s = exp_st.pop_front();
                    check("status_done_err_code_busy_cycle",
                          64'({done, error, err_code, busy, cur}),
                          64'({s.done, s.error, s.code, 1'b0, s.cyc}));
                    check("valids_low_at_end",
                          64'({cfg.axi_awvalid, cfg.axi_wvalid, cfg.axi_arvalid, cfg.axi_rready, cc_ls_enable}),
                          64'd0);
                end
            end
            prev_fin = done || error;
        end
    endtask

    task automatic push_writes(input int n);
        wbeat_t b;
        exp_aw.push_back(12'h000);
        b.data = 32'h0000_0001; b.strb = 4'hF;
        exp_w.push_back(b);
        if (n > 1) begin
            exp_aw.push_back(12'h000);
            b.data = 32'h0000_0003; b.strb = 4'hF;
            exp_w.push_back(b);
        end
    endtask

    task automatic push_full(input logic [31:0] cyc, input logic [1:0] code);
        stat_t s;
        push_writes(2);
        exp_ar.push_back(12'h000);
        s.done = (code == ERR_NONE);
        s.error = (code != ERR_NONE);
        s.code = code;
        s.cyc = cyc;
        exp_st.push_back(s);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge axi_clk);
        t_start = $time;
        #1 start = 1'b0;
    endtask

    task automatic wait_fin(input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(posedge axi_clk);
            #1;
            n++;
        end
        check("finish_within_budget", 64'(done || error), 64'd1);
    endtask

    task automatic settle();
        repeat (2) @(posedge axi_clk);
        #1;
    endtask

    initial begin
        int a0, w0;
        stat_t s;
        axi_reset_n = 1'b0;
        start = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(posedge axi_clk);
        #1;
        check("reset_flags", 64'({busy, done, error, err_code, cc_ls_enable,
                                  cfg.axi_awvalid, cfg.axi_wvalid, cfg.axi_arvalid, cfg.axi_rready}), 64'd0);
        check("reset_buses", 64'({cfg.axi_awaddr, cfg.axi_wdata, cfg.axi_wstrb, cfg.axi_araddr}), 64'd0);
        axi_reset_n = 1'b1;
        settle();

        // Always-ready slave: done at cycle TX_DLY+5.
        push_full(32'(TX_DLY + 5), ERR_NONE);
        a0 = awv_cyc; w0 = wv_cyc;
        pulse_start();
        check("cycle1_valids_busy", 64'({cfg.axi_awvalid, cfg.axi_wvalid, busy, cc_ls_enable}), 64'hF);
        wait_fin(100);
        settle();
        check("s1_levels", 64'({done, error, err_code, busy}), 64'b1000_0);
        check("s1_valid_cycles", 64'({32'(awv_cyc - a0), 32'(wv_cyc - w0)}), {32'd2, 32'd2});

        // awready 3 cycles late in both write phases: each phase stretches by 3.
        aw_dly = 3;
        push_full(32'(TX_DLY + 11), ERR_NONE);
        a0 = awv_cyc; w0 = wv_cyc;
        pulse_start();
        wait_fin(100);
        settle();
        check("s2_valid_cycles", 64'({32'(awv_cyc - a0), 32'(wv_cyc - w0)}), {32'd8, 32'd2});
        check("s2_done", 64'({done, error}), 64'b10);
        aw_dly = 0;

        // Both write readies stuck low: write timeout after TMO cycles in WR_RX.
        aw_dly = 100000; w_dly = 100000;
        s.done = 1'b0; s.error = 1'b1; s.code = ERR_WR_TIMEOUT; s.cyc = 32'(TMO + 1);
        exp_st.push_back(s);
        pulse_start();
        wait_fin(400);
        repeat (5) @(posedge axi_clk);
        #1;
        check("s3_levels", 64'({done, error, err_code, busy}), 64'b0101_0);
        check("s3_valids_stay_low", 64'({cfg.axi_awvalid, cfg.axi_wvalid, cfg.axi_arvalid, cfg.axi_rready}), 64'd0);
        aw_dly = 0; w_dly = 0;
        settle();

        // Readback with txen missing: mismatch error, restart from ERR.
        bad_rd = 1'b1;
        push_full(32'(TX_DLY + 5), ERR_MISMATCH);
        pulse_start();
        check("s4_restart_clears", 64'({done, error, err_code}), 64'd0);
        wait_fin(100);
        settle();
        check("s4_levels", 64'({done, error, err_code}), 64'b0111);
        bad_rd = 1'b0;

        // Reset in cycle 10 (DLY): outputs drop at once, then a clean rerun.
        push_writes(1);
        pulse_start();
        repeat (9) @(posedge axi_clk);
        #2 axi_reset_n = 1'b0;
        #1;
        check("s5_async_reset_flags", 64'({busy, done, error, err_code, cc_ls_enable,
                                           cfg.axi_awvalid, cfg.axi_wvalid, cfg.axi_arvalid, cfg.axi_rready}), 64'd0);
        check("s5_async_reset_wdata", 64'({cfg.axi_wdata, cfg.axi_wstrb}), 64'd0);
        repeat (2) @(posedge axi_clk);
        #1 axi_reset_n = 1'b1;
        repeat (30) @(posedge axi_clk);
        #1;
        check("s5_idle_after_reset", 64'({busy, done, error}), 64'd0);
        push_full(32'(TX_DLY + 5), ERR_NONE);
        pulse_start();
        wait_fin(100);
        settle();
        check("s5_rerun_done", 64'({done, error}), 64'b10);

        // Start from DONE reruns; a second start during DLY is ignored.
        push_full(32'(TX_DLY + 5), ERR_NONE);
        pulse_start();
        check("s6_done_clears", 64'({done, busy}), 64'b01);
        repeat (6) @(posedge axi_clk);
        #1 start = 1'b1;
        @(posedge axi_clk);
        #1 start = 1'b0;
        wait_fin(100);
        settle();
        check("s6_done", 64'({done, error, err_code}), 64'b1000);

        repeat (3) @(posedge axi_clk);
        #1;
        check("scoreboard_drained", 64'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_st.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
